adc_cassette_slicer: RTL and testbench

ADC_CASSETTE_SLICER -- requirements
Module: adc_cassette_slicer

---
 rtl/adc_cassette_slicer.sv | 242 ++++++++++++++++++++++++
 tb/tb_adc_cassette_slicer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_cassette_slicer.sv
// Cassette-tape ADC slicer: moving-average baseline, hysteretic slicing, edge and overrun flags.
// Optional period measurement between slice edges is enabled by defining CAS_PERIOD_EN.
module adc_cassette_slicer #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned AVG_LOG2 = 9,
  parameter int unsigned PER_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] smp_data,
  input  logic              smp_tgl,
  input  logic [DATA_W-1:0] hyst,
  input  logic              invert,
  input  logic              clear,
  output logic [DATA_W-1:0] avg_out,
  output logic              avg_valid,
  output logic              slice_bit,
  output logic              edge_pulse,
  output logic [PER_W-1:0]  period,
  output logic              period_valid,
  output logic              ovf_err
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned TW    = DATA_W + AVG_LOG2;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [DATA_W:0] MAX_X = {1'b0, {DATA_W{1'b1}}};

  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                tgl_q,       tgl_d;
  logic [DATA_W-1:0]   smp_q,       smp_d;
  logic [DATA_W-1:0]   hyst_q,      hyst_d;
  logic [DATA_W-1:0]   oldest_q,    oldest_d;
  logic                v1_q,        v1_d;
  logic                v2_q,        v2_d;
  logic                v3_q,        v3_d;
  logic [AVG_LOG2-1:0] ptr_q,       ptr_d;
  logic [TW-1:0]       total_q,     total_d;
  logic [DATA_W-1:0]   avg_q,       avg_d;
  logic                avg_valid_q, avg_valid_d;
  logic [0:0]          state_q,     state_d;
  logic                raw_q,       raw_d;
  logic                slice_q,     slice_d;
  logic                edge_q,      edge_d;
  logic                ovf_q,       ovf_d;

  logic                new_smp;
  logic                busy;
  logic                accept;
  logic                mem_we;
  logic [DATA_W-1:0]   oldest_term;
  logic [DATA_W:0]     avg_x;
  logic [DATA_W:0]     hyst_x;
  logic [DATA_W:0]     smp_x;
  logic [DATA_W:0]     sum_x;
  logic [DATA_W:0]     lo_x;
  logic [DATA_W:0]     hi_x;

  // Thresholds in one extra bit so avg-hyst and avg+hyst clamp instead of wrapping.
  always_comb begin
    avg_x  = {1'b0, avg_q};
    hyst_x = {1'b0, hyst_q};
    smp_x  = {1'b0, smp_q};
    sum_x  = avg_x + hyst_x;
    lo_x   = (hyst_x > avg_x) ? '0 : (avg_x - hyst_x);
    hi_x   = (sum_x > MAX_X) ? MAX_X : sum_x;
  end

  always_comb begin
    tgl_d       = smp_tgl;
    smp_d       = smp_q;
    hyst_d      = hyst_q;
    oldest_d    = oldest_q;
    ptr_d       = ptr_q;
    total_d     = total_q;
    avg_d       = avg_q;
    avg_valid_d = avg_valid_q;
    state_d     = state_q;
    raw_d       = raw_q;
    ovf_d       = ovf_q;
    mem_we      = 1'b0;

    new_smp     = (smp_tgl != tgl_q);
    busy        = v1_q | v2_q | v3_q;
    accept      = new_smp & ~busy & ~clear;
    oldest_term = (state_q == ST_FILL) ? '0 : oldest_q;

    v1_d = accept;
    v2_d = v1_q;
    v3_d = v2_q;

    // S0: capture sample, its hysteresis and the entry it will overwrite.
    if (accept) begin
      smp_d    = smp_data;
      hyst_d   = hyst;
      oldest_d = mem_q[ptr_q];
    end
    if (new_smp && busy && !clear) begin
      ovf_d = 1'b1;
    end

    // S1: running sum and buffer write.
    if (v1_q) begin
      total_d = total_q - {{AVG_LOG2{1'b0}}, oldest_term} + {{AVG_LOG2{1'b0}}, smp_q};
      mem_we  = 1'b1;
      ptr_d   = ptr_q + 1'b1;
      if (state_q == ST_FILL && (&ptr_q)) begin
        state_d = ST_RUN;
      end
    end

    // S2: average.
    if (v2_q) begin
      avg_d       = total_q[TW-1:AVG_LOG2];
      avg_valid_d = (state_q == ST_RUN);
    end

    // S3: slice against the freshly updated average.
    if (v3_q && avg_valid_q) begin
      if (smp_x < lo_x) begin
        raw_d = 1'b1;
      end else if (smp_x > hi_x) begin
        raw_d = 1'b0;
      end
    end

    if (clear) begin
      total_d     = '0;
      ptr_d       = '0;
      avg_d       = '0;
      avg_valid_d = 1'b0;
      state_d     = ST_FILL;
      v1_d        = 1'b0;
      v2_d        = 1'b0;
      v3_d        = 1'b0;
      mem_we      = 1'b0;
    end

    slice_d = raw_d ^ invert;
    edge_d  = (slice_d != slice_q);
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[ptr_q] <= smp_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgl_q       <= 1'b0;
      smp_q       <= '0;
      hyst_q      <= '0;
      oldest_q    <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      ptr_q       <= '0;
      total_q     <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      state_q     <= ST_FILL;
      raw_q       <= 1'b0;
      slice_q     <= 1'b0;
      edge_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      tgl_q       <= tgl_d;
      smp_q       <= smp_d;
      hyst_q      <= hyst_d;
      oldest_q    <= oldest_d;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      v3_q        <= v3_d;
      ptr_q       <= ptr_d;
      total_q     <= total_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      state_q     <= state_d;
      raw_q       <= raw_d;
      slice_q     <= slice_d;
      edge_q      <= edge_d;
      ovf_q       <= ovf_d;
    end
  end

  assign avg_out    = avg_q;
  assign avg_valid  = avg_valid_q;
  assign slice_bit  = slice_q;
  assign edge_pulse = edge_q;
  assign ovf_err    = ovf_q;

`ifdef CAS_PERIOD_EN
  logic [PER_W-1:0] cnt_q,    cnt_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             pv_q,     pv_d;
  logic             seen_q,   seen_d;

  // The first edge after reset only starts the count; there is no prior edge to measure from.
  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    pv_d     = 1'b0;
    seen_d   = seen_q;
    if (edge_q) begin
      cnt_d  = PER_W'(1);
      seen_d = 1'b1;
      if (seen_q) begin
        period_d = cnt_q;
        pv_d     = 1'b1;
      end
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      seen_q   <= seen_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
`else
  assign period       = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adc_cassette_slicer.sv
// Directed bench for adc_cassette_slicer with a 4-sample window and hand-computed expectations.
module tb_adc_cassette_slicer;

  localparam int DW = 12;
  localparam int AL = 2;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] smp_data;
  logic          smp_tgl;
  logic [DW-1:0] hyst;
  logic          invert;
  logic          clear;
  logic [DW-1:0] avg_out;
  logic          avg_valid;
  logic          slice_bit;
  logic          edge_pulse;
  logic [PW-1:0] period;
  logic          period_valid;
  logic          ovf_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  adc_cassette_slicer #(
    .DATA_W  (DW),
    .AVG_LOG2(AL),
    .PER_W   (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .smp_data    (smp_data),
    .smp_tgl     (smp_tgl),
    .hyst        (hyst),
    .invert      (invert),
    .clear       (clear),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .slice_bit   (slice_bit),
    .edge_pulse  (edge_pulse),
    .period      (period),
    .period_valid(period_valid),
    .ovf_err     (ovf_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents a sample; returns just after the accepting edge.
  task automatic drive(input logic [DW-1:0] v, input logic [DW-1:0] h);
    hyst     = h;
    smp_data = v;
    smp_tgl  = ~smp_tgl;
    tick(1);
  endtask

  task automatic step(input string tag, input int v, input int h, input int exp_avg,
                      input int exp_valid, input int exp_slice, input int exp_edge);
    drive(DW'(v), DW'(h));
    tick(2);
    check_eq({tag, "_avg"}, 32'(avg_out), exp_avg);
    check_eq({tag, "_valid"}, 32'(avg_valid), exp_valid);
    tick(1);
    check_eq({tag, "_slice"}, 32'(slice_bit), exp_slice);
    check_eq({tag, "_edge"}, 32'(edge_pulse), exp_edge);
    tick(1);
    check_eq({tag, "_edge_end"}, 32'(edge_pulse), 0);
    tick(4);
  endtask

  initial begin
    int pv_acc;
    reset    = 1'b1;
    smp_data = '0;
    smp_tgl  = 1'b0;
    hyst     = DW'(100);
    invert   = 1'b0;
    clear    = 1'b0;
    tick(2);
    check_eq("rst_avg", 32'(avg_out), 0);
    check_eq("rst_valid", 32'(avg_valid), 0);
    check_eq("rst_slice", 32'(slice_bit), 0);
    check_eq("rst_edge", 32'(edge_pulse), 0);
    check_eq("rst_ovf", 32'(ovf_err), 0);
    check_eq("rst_period", 32'(period), 0);
    check_eq("rst_pv", 32'(period_valid), 0);
    reset = 1'b0;
    tick(2);

    // Fill with 2048: running average 512, 1024, 1536, 2048.
    step("fill0", 2048, 100,  512, 0, 0, 0);
    step("fill1", 2048, 100, 1024, 0, 0, 0);
    step("fill2", 2048, 100, 1536, 0, 0, 0);
    step("fill3", 2048, 100, 2048, 1, 0, 0);

    step("s1900", 1900, 100, 2011, 1, 1, 1);
    step("s2000", 2000, 100, 1999, 1, 1, 0);

    // Wide hysteresis walks the average up without slicing.
    step("up0", 4050, 4095, 2499, 1, 1, 0);
    step("up1", 4050, 4095, 3000, 1, 1, 0);
    step("up2", 4050, 4095, 3537, 1, 1, 0);
    step("up3", 4050, 4095, 4050, 1, 1, 0);
    step("hiclamp", 4095, 100, 4061, 1, 1, 0);
    step("hifall", 4095, 0, 4072, 1, 0, 1);

    step("dn0", 50, 4095, 3072, 1, 0, 0);
    step("dn1", 50, 4095, 2072, 1, 0, 0);
    step("dn2", 50, 4095, 1061, 1, 0, 0);
    step("dn3", 50, 4095,   50, 1, 0, 0);
    step("loclamp", 0, 100, 37, 1, 0, 0);

    // Overrun: second toggle 2 clk after acceptance.
    drive(DW'(1000), DW'(100));
    tick(1);
    check_eq("ovf_before", 32'(ovf_err), 0);
    smp_data = DW'(4000);
    smp_tgl  = ~smp_tgl;
    tick(1);
    check_eq("ovf_avg", 32'(avg_out), 275);
    tick(1);
    check_eq("ovf_set", 32'(ovf_err), 1);
    check_eq("ovf_slice", 32'(slice_bit), 0);
    tick(6);
    step("ovf_next", 1000, 100, 512, 1, 0, 0);
    check_eq("ovf_sticky", 32'(ovf_err), 1);

    // Invert-driven edges.
    invert = 1'b1;
    tick(1);
    check_eq("inv_slice", 32'(slice_bit), 1);
    check_eq("inv_edge", 32'(edge_pulse), 1);
    tick(1);
    check_eq("inv_edge_end", 32'(edge_pulse), 0);
`ifndef CAS_PERIOD_EN
    check_eq("noper_period", 32'(period), 0);
    check_eq("noper_pv", 32'(period_valid), 0);
`endif
    invert = 1'b0;
    tick(1);
    check_eq("uninv_slice", 32'(slice_bit), 0);
    check_eq("uninv_edge", 32'(edge_pulse), 1);
    tick(3);

    // Clear coinciding with a sample edge.
    clear = 1'b1;
    drive(DW'(3000), DW'(100));
    clear = 1'b0;
    check_eq("clr_valid", 32'(avg_valid), 0);
    check_eq("clr_avg", 32'(avg_out), 0);
    tick(4);
    check_eq("clr_ignored", 32'(avg_out), 0);
    check_eq("clr_ovf_kept", 32'(ovf_err), 1);
    step("ref0", 400, 100, 100, 0, 0, 0);
    step("ref1", 400, 100, 200, 0, 0, 0);
    step("ref2", 400, 100, 300, 0, 0, 0);
    step("ref3", 400, 100, 400, 1, 0, 0);

    // Reset while a slicing sample is in flight.
    drive(DW'(100), DW'(100));
    tick(1);
    reset   = 1'b1;
    smp_tgl = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(4);
    check_eq("mid_avg", 32'(avg_out), 0);
    check_eq("mid_valid", 32'(avg_valid), 0);
    check_eq("mid_slice", 32'(slice_bit), 0);
    check_eq("mid_edge", 32'(edge_pulse), 0);
    check_eq("mid_ovf", 32'(ovf_err), 0);

`ifdef CAS_PERIOD_EN
    pv_acc = 0;
    invert = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      pv_acc += int'(period_valid);
    end
    check_eq("per_first_none", 32'(pv_acc), 0);
    invert = 1'b0;
    tick(1);
    check_eq("per_edge2", 32'(edge_pulse), 1);
    tick(1);
    check_eq("per_pv", 32'(period_valid), 1);
    check_eq("per_500", 32'(period), 500);
    tick(1);
    check_eq("per_pv_end", 32'(period_valid), 0);
    tick(70000);
    invert = 1'b1;
    tick(2);
    check_eq("per_sat_pv", 32'(period_valid), 1);
    check_eq("per_sat", 32'(period), 65535);
`else
    pv_acc = 0;
    invert = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      pv_acc += int'(period_valid);
    end
    check_eq("noper_pv_none", 32'(pv_acc), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
